// File: rtl/aqalu_trace_pkg.sv
// Shared definitions for the AQALU trace recorder: record layout, FSM encodings
// and the tap tuple type.
package aqalu_trace_pkg;

   localparam int TRACE_REC_W = 24;

   localparam int A_LSB   = 22;
   localparam int B_LSB   = 20;
   localparam int OP_LSB  = 16;
   localparam int OUT_LSB = 8;
   localparam int SEC_LSB = 0;

   localparam int A_W   = 2;
   localparam int B_W   = 2;
   localparam int OP_W  = 4;
   localparam int OUT_W = 8;
   localparam int REC_SEC_W = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARM   = 2'd1;
   localparam logic [1:0] ST_TRACK = 2'd2;

   localparam logic [3:0] OPC_SEQ = 4'b1111;

   typedef struct packed {
      logic [A_W-1:0]  a;
      logic [B_W-1:0]  b;
      logic [OP_W-1:0] opcode;
   } tuple_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO. A push is taken when there is
// room or when a pop frees a slot in the same cycle.
module trace_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             doPop;
   logic             doPush;

   assign empty  = (wrPtr == rdPtr);
   assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);

   // Head is presented directly; an empty FIFO shows zero rather than stale data
   assign popData = empty ? '0 : mem[rdPtr[AW-1:0]];

   // Pointer update; the extra MSB separates full from empty
   always_ff @(posedge clock) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
      end
   end

   // Storage write, no reset needed on data
   always_ff @(posedge clock) begin
      if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
   end

endmodule

// File: rtl/aqalu_trace_recorder.sv
// AQALU trace writer: times how long each {A,B,Opcode} vector is held and
// retires it as a 24-bit record into a FIFO drained over valid/ready.
module aqalu_trace_recorder
   import aqalu_trace_pkg::*;
#(
   parameter int TICKS_PER_SEC = 1000,
   parameter int FIFO_DEPTH    = 16,
   parameter int SEC_W         = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   capture_en,
   input  logic                   flush,
   input  logic [1:0]             A,
   input  logic [1:0]             B,
   input  logic [3:0]             Opcode,
   input  logic [7:0]             Output,
   output logic [TRACE_REC_W-1:0] rec_data,
   output logic                   rec_valid,
   input  logic                   rec_ready,
   output logic                   overflow,
   output logic [7:0]             drop_count
);

   localparam int TW = $clog2(TICKS_PER_SEC + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);

   logic [1:0]             state;
   tuple_t                 inTuple;
   tuple_t                 curTuple;
   logic [7:0]             lastOut;
   logic [TW-1:0]          tickCnt;
   logic [SEC_W-1:0]       secCnt;
   logic                   recPush;
   logic [TRACE_REC_W-1:0] recWord;
   logic                   popReq;
   logic                   fifoFull;
   logic                   fifoEmpty;
   logic                   dropEvt;

   function automatic logic [SEC_W-1:0] secSatInc(input logic [SEC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   function automatic logic [7:0] dropSatInc(input logic [7:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign inTuple   = {A, B, Opcode};
   assign recWord   = {curTuple, lastOut, 8'(secCnt)};
   assign rec_valid = !fifoEmpty;
   assign popReq    = rec_valid && rec_ready;
   assign dropEvt   = recPush && fifoFull && !popReq;

   // Retire on capture drop, flush or tuple change; at most one record per cycle
   always_comb begin
      recPush = 1'b0;
      if (state == ST_TRACK)
         recPush = !capture_en || flush || (inTuple != curTuple);
   end

   // Capture FSM and hold-time counters
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         tickCnt <= '0;
         secCnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tickCnt <= '0;
               secCnt  <= '0;
               if (capture_en) state <= ST_ARM;
            end
            ST_ARM: begin
               tickCnt <= TW'(1);
               secCnt  <= '0;
               state   <= ST_TRACK;
            end
            ST_TRACK: begin
               if (!capture_en) begin
                  tickCnt <= '0;
                  secCnt  <= '0;
                  state   <= ST_IDLE;
               end else if (flush || (inTuple != curTuple)) begin
                  tickCnt <= TW'(1);
                  secCnt  <= '0;
               end else if (tickCnt >= TICK_LAST) begin
                  tickCnt <= '0;
                  secCnt  <= secSatInc(secCnt);
               end else begin
                  tickCnt <= tickCnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Tuple and settled-output capture; the change cycle's Output belongs to the new vector
   always_ff @(posedge clock) begin
      if (state == ST_ARM) begin
         curTuple <= inTuple;
         lastOut  <= Output;
      end else if (state == ST_TRACK) begin
         lastOut <= Output;
         if (capture_en && !flush && (inTuple != curTuple)) curTuple <= inTuple;
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (dropEvt) begin
         overflow   <= 1'b1;
         drop_count <= dropSatInc(drop_count);
      end
   end

   trace_fifo #(
      .WIDTH(TRACE_REC_W),
      .DEPTH(FIFO_DEPTH)
   ) uFifo (
      .clock    (clock),
      .reset    (reset),
      .push     (recPush),
      .pushData (recWord),
      .pop      (popReq),
      .popData  (rec_data),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

endmodule

// File: doc/aqalu_trace_recorder.md
Name: aqalu_trace_recorder

Overview:
Hardware trace writer for the AQALU. It monitors the ALU's input tuple {A, B, Opcode} and its Output, and retires each held vector as one record. A record holds A, B, Opcode, the final Output, and the whole seconds the vector was held, which is the same five-field format the vector-file bench consumes. Records are buffered in a FIFO and drained over a valid/ready port to a UART or memory dumper, so a traced session can be replayed by the bench.

Parameters:
TICKS_PER_SEC, 1000, clock cycles per "second" (10_000_000 for real time at 10 MHz)
FIFO_DEPTH, 16, record buffer depth; power of two, >= 2
SEC_W, 8, width of the seconds field

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
capture_en  input  1  tracing enable
flush  input  1  single-cycle pulse: retire current vector now
A  input  2  AQALU operand A (tap)
B  input  2  AQALU operand B (tap)
Opcode  input  4  AQALU opcode (tap)
Output  input  8  AQALU result (tap)
rec_data  output  24  {A[1:0],B[1:0],Opcode[3:0],Output[7:0],seconds[7:0]}, MSB first
rec_valid  output  1  rec_data holds a record
rec_ready  input  1  consumer accepts; pop when rec_valid&&rec_ready
overflow  output  1  sticky: a record was dropped
drop_count  output  8  dropped records, saturating at 255

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clock, reset port is reset.
- Reset values: rec_valid=0, rec_data=0, overflow=0, drop_count=0, FIFO empty, state IDLE, all counters 0.
- Reset asserted mid-vector discards the partial vector and any buffered records.
- State machine:
  - IDLE: entered when capture_en=0. Taps ignored. Go to ARM when capture_en=1.
  - ARM: single cycle. Latch the tuple into cur_tuple and Output into last_out. Set tick_cnt=1, sec_cnt=0. Go to TRACK.
  - TRACK: every cycle last_out<=Output. Retire on:
    - tuple change (inputs != cur_tuple): retire, then load the new tuple with tick_cnt=1, sec_cnt=0. Output on the change cycle belongs to the new vector.
    - flush=1: retire, then restart timing on the same tuple.
    - capture_en=0: retire, go to IDLE.
  - Priority: capture_en drop > flush > tuple change. Only one record is produced per cycle.
- Timing: tick_cnt counts cycles the vector is present. On tick_cnt reaching TICKS_PER_SEC, tick_cnt wraps to 0 and sec_cnt increments. sec_cnt saturates at 2^SEC_W-1, so seconds = min(floor(cycles/TICKS_PER_SEC), 255).
- Retire: the record {cur_tuple, last_out, sec_cnt} is pushed at the detecting edge. last_out is Output as sampled one edge earlier, i.e. the final settled value.
- Latency: change seen at edge N means rec_valid=1 after edge N, provided the FIFO was empty.
- FIFO:
  - rec_data and rec_valid come straight from the head, first-word-fall-through.
  - A push is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Push and pop in the same cycle on an empty FIFO: no pop occurs (rec_valid was 0), and the push lands.
  - A push while full with no pop is dropped: overflow<=1 (sticky until reset) and drop_count increments, saturating at 255.
- Pointers wrap modulo FIFO_DEPTH. An extra count bit distinguishes full from empty.

Decomposition:
- Package aqalu_trace_pkg: TRACE_REC_W=24; field offsets and widths (A_LSB=22, B_LSB=20, OP_LSB=16, OUT_LSB=8, SEC_LSB=0); state encodings IDLE/ARM/TRACK; OPC_SEQ=4'b1111 for benches.
- Sub-module trace_fifo: a synchronous FWFT FIFO parameterised by width and depth, exposing full/empty and push/pop.
- Capture FSM and timers live in the top level.

Test Plan:
1. Assert reset for 2 cycles with random taps -> rec_valid=0, overflow=0, drop_count=0; no record appears while capture_en=0.
2. TICKS_PER_SEC=4, capture_en=1, hold A=1,B=2,Opcode=0000,Output=8'h03 for 9 cycles, then change A=3 -> exactly one record, rec_data=24'h600302 (seconds 2); the new vector starts timing.
3. Hold a vector 3 cycles then change it -> seconds=0. Hold Opcode=1111 for 1100 cycles -> seconds saturates at 8'hFF.
4. FIFO_DEPTH=4, rec_ready=0, force 6 retirements -> 4 records retained in order, overflow=1, drop_count=2. Then rec_ready=1 -> the 4 records drain oldest-first.
5. FIFO full with a retire and a pop in the same cycle -> push accepted, drop_count unchanged, occupancy stays 4.
6. Reset mid-TRACK, then flush during TRACK -> reset yields no record for the partial vector. flush emits one record with the current tuple and restarts seconds at 0. A capture_en falling edge emits a final record.
